// File: rtl/ibusif_pf_if.sv
// ibusif_pf_if: instruction-side AHB-lite bundle between ibusif_pf (master) and its slave
interface ibusif_pf_if;
    logic [31:0] haddr;
    logic        hprot;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        htrans;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;
    modport master (output haddr, hprot, hsize, hwrite, hwdata, htrans, input hrdata, hresp, hready);
    modport slave (input haddr, hprot, hsize, hwrite, hwdata, htrans, output hrdata, hresp, hready);
endinterface

// File: rtl/ibusif_pf.sv
// ibusif_pf: prefetching AHB-lite instruction fetcher feeding a halfword FIFO to pipeline stage 0
module ibusif_pf #(
    parameter int unsigned DEPTH_W    = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jmp_req,
    input  logic [31:0]      jmp_addr,
    input  logic             instr_fetch,
    input  logic [1:0]       instr_fetch_size,
    output logic [1:0]       instr_vld_size,
    output logic [31:0]      instr,
    output logic             instr_has_fault,
    ibusif_pf_if.master      bus
);
    localparam int unsigned NH = 2 * DEPTH_W;
    localparam int unsigned AW = $clog2(NH);

    logic [15:0]   hw_q [NH];
    logic [NH-1:0] flt_q;
    logic [AW-1:0] rd_q, wr_q, rd1, wr1;
    logic [AW:0]   cnt_q;
    logic [31:1]   fptr_q;
    logic          halt_q, dph_q, disc_q, half_q;
    logic          accept, complete, push;
    logic [1:0]    n_push, n_req, n_pop, vld_n;
    logic [AW+1:0] credit;
    logic          unused_bits;

    assign unused_bits = ^{instr_fetch_size[1], jmp_addr[0]};
    assign rd1 = rd_q + AW'(1);
    assign wr1 = wr_q + AW'(1);

    // A lone halfword left behind a fault is shown as 32-bit so the consumer drains it as faulted
    assign instr_vld_size = (cnt_q >= (AW+1)'(2) || (cnt_q == (AW+1)'(1) && halt_q)) ? 2'b10 :
                            cnt_q == (AW+1)'(1) ? 2'b01 : 2'b00;
    assign instr = {hw_q[rd1], hw_q[rd_q]};
    assign instr_has_fault = (cnt_q != '0 && flt_q[rd_q]) || (cnt_q >= (AW+1)'(2) && flt_q[rd1]);
    assign vld_n = instr_vld_size[1] ? 2'd2 : {1'b0, instr_vld_size[0]};

    // Credit reserves FIFO room for the data phase in flight plus the one about to be issued
    assign credit = (AW+2)'(cnt_q) + (AW+2)'({dph_q, 1'b0}) + (AW+2)'(2);
    assign bus.htrans = !rst && !halt_q && !jmp_req && credit <= (AW+2)'(NH);
    assign bus.haddr  = {fptr_q[31:2], 2'b00};
    assign bus.hprot  = 1'b0;
    assign bus.hsize  = 2'b10;
    assign bus.hwrite = 1'b0;
    assign bus.hwdata = 32'h0;

    assign accept   = bus.htrans && bus.hready;
    assign complete = dph_q && bus.hready;
    assign push     = complete && !disc_q && !halt_q && !jmp_req;
    assign n_push   = push ? (half_q ? 2'd1 : 2'd2) : 2'd0;
    assign n_req    = (instr_fetch && !jmp_req) ? (instr_fetch_size[0] ? 2'd1 : 2'd2) : 2'd0;
    assign n_pop    = (AW+1)'(n_req) > cnt_q ? cnt_q[1:0] : n_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            fptr_q <= RESET_ADDR[31:1];
            halt_q <= 1'b0;
            dph_q  <= 1'b0;
            disc_q <= 1'b0;
            half_q <= 1'b0;
        end else begin
            dph_q <= accept || (dph_q && !bus.hready);
            if (accept) begin
                disc_q <= 1'b0;
                half_q <= fptr_q[1];
            end else if (jmp_req) begin
                disc_q <= 1'b1;
            end
            if (jmp_req) begin
                rd_q   <= '0;
                wr_q   <= '0;
                cnt_q  <= '0;
                halt_q <= 1'b0;
                fptr_q <= jmp_addr[31:1];
            end else begin
                rd_q  <= rd_q + AW'(n_pop);
                wr_q  <= wr_q + AW'(n_push);
                cnt_q <= cnt_q + (AW+1)'(n_push) - (AW+1)'(n_pop);
                if (complete && bus.hresp && !disc_q) halt_q <= 1'b1;
                if (accept) fptr_q <= {fptr_q[31:2] + 30'd1, 1'b0};
            end
        end
    end

    // Low halfword first; an odd jump target skips the low half of its first word
    always_ff @(posedge clk) begin
        if (push) begin
            hw_q[wr_q]  <= half_q ? bus.hrdata[31:16] : bus.hrdata[15:0];
            flt_q[wr_q] <= bus.hresp;
            if (!half_q) begin
                hw_q[wr1]  <= bus.hrdata[31:16];
                flt_q[wr1] <= bus.hresp;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) (instr_fetch && !jmp_req) |-> n_req <= vld_n);
endmodule

// File: tb/tb_ibusif_pf.sv
// tb_ibusif_pf: queue-based reference model of ibusif_pf with a per-cycle compare and directed scenarios
module tb_ibusif_pf;
    localparam int D  = 4;
    localparam int NH = 2 * D;

    typedef struct {
        logic [31:0] addr;
        bit          disc;
        bit          half;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jmp_req = 1'b0;
    logic [31:0] jmp_addr = 32'h0;
    logic        instr_fetch = 1'b0;
    logic [1:0]  instr_fetch_size = 2'b10;
    logic [1:0]  instr_vld_size;
    logic [31:0] instr;
    logic        instr_has_fault;

    ibusif_pf_if bus();

    ibusif_pf #(.DEPTH_W(D), .RESET_ADDR(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .jmp_req(jmp_req),
        .jmp_addr(jmp_addr),
        .instr_fetch(instr_fetch),
        .instr_fetch_size(instr_fetch_size),
        .instr_vld_size(instr_vld_size),
        .instr(instr),
        .instr_has_fault(instr_has_fault),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [16:0] q[$];
    xfer_t       dq[$];
    logic [31:0] fptr = 32'h0;
    bit          halt = 1'b0;
    int          stall_left = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          err_waited = 1'b0;
    int          mode = 0;
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;
    bit          chk_en = 1'b0;
    int          e_n;
    logic [1:0]  e_vld;
    logic [31:0] e_instr;
    logic        e_flt, e_htrans;
    logic [31:0] e_haddr;
    logic [31:0] got_i[$];
    logic        got_f[$];
    int          acc_cnt = 0;

    function automatic logic [31:0] word(logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("vld_size", 32'(instr_vld_size), 32'(e_vld));
            check("has_fault", 32'(instr_has_fault), 32'(e_flt));
            check("htrans", 32'(bus.htrans), 32'(e_htrans));
            check("haddr", bus.haddr, e_haddr);
            if (e_n >= 1) check("instr_lo", 32'(instr[15:0]), 32'(e_instr[15:0]));
            if (e_n >= 2) check("instr_hi", 32'(instr[31:16]), 32'(e_instr[31:16]));
        end
    end

    task automatic step();
        bit hr, comp, acc, resp;
        int n, k;
        xfer_t t;
        logic [31:0] w;
        n = q.size();
        hr = stall_left == 0;
        if (stall_left > 0) stall_left--;
        if (dq.size() > 0 && dq[0].addr == err_addr && !err_waited) begin
            hr = 1'b0;
            err_waited = 1'b1;
        end
        resp = hr && dq.size() > 0 && dq[0].addr == err_addr;
        bus.hready = hr;
        bus.hresp  = resp;
        bus.hrdata = dq.size() > 0 ? word(dq[0].addr) : 32'h0;
        e_n = n;
        e_vld = n >= 2 ? 2'b10 : n == 1 ? (halt ? 2'b10 : 2'b01) : 2'b00;
        e_instr = {n >= 2 ? q[1][15:0] : 16'h0, n >= 1 ? q[0][15:0] : 16'h0};
        e_flt = (n >= 1 && q[0][16]) || (n >= 2 && q[1][16]);
        e_htrans = !rst && !halt && !jmp_req && (n + 2 * dq.size() + 2 <= NH);
        e_haddr = fptr & ~32'h3;
        instr_fetch = mode == 1 ? e_vld[1] : mode == 2 ? (e_vld != 2'b00) : 1'b0;
        instr_fetch_size = mode == 2 ? 2'b01 : 2'b10;
        chk_en = started;
        #1;
        if (instr_fetch && !jmp_req && !rst) begin
            got_i.push_back(instr);
            got_f.push_back(instr_has_fault);
        end
        if (!rst && bus.htrans && bus.hready) acc_cnt++;
        @(posedge clk);
        started = 1'b1;
        comp = dq.size() > 0 && hr;
        acc = e_htrans && hr;
        if (rst) begin
            q.delete();
            dq.delete();
            fptr = 32'h0;
            halt = 1'b0;
        end else if (jmp_req) begin
            q.delete();
            halt = 1'b0;
            fptr = {jmp_addr[31:1], 1'b0};
            if (comp) void'(dq.pop_front());
            foreach (dq[i]) dq[i].disc = 1'b1;
        end else begin
            k = instr_fetch ? (instr_fetch_size[0] ? 1 : 2) : 0;
            repeat (k) if (q.size() > 0) void'(q.pop_front());
            if (comp) begin
                t = dq.pop_front();
                w = word(t.addr);
                if (!t.disc && !halt) begin
                    if (!t.half) q.push_back({resp, w[15:0]});
                    q.push_back({resp, w[31:16]});
                end
                if (resp && !t.disc) halt = 1'b1;
            end
            if (acc) begin
                t.addr = fptr & ~32'h3;
                t.disc = 1'b0;
                t.half = fptr[1];
                dq.push_back(t);
                fptr = (fptr & ~32'h3) + 32'd4;
            end
        end
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic jump(logic [31:0] a);
        jmp_req = 1'b1;
        jmp_addr = a;
        step();
        jmp_req = 1'b0;
    endtask

    task automatic clear_got();
        got_i.delete();
        got_f.delete();
    endtask

    initial begin
        bus.hready = 1'b1;
        bus.hresp = 1'b0;
        bus.hrdata = 32'h0;
        rst = 1'b1;
        run(2);
        check("reset_vld", 32'(instr_vld_size), 32'h0);
        check("reset_htrans", 32'(bus.htrans), 32'h0);
        check("reset_haddr", bus.haddr, 32'h0);
        check("hsize", 32'(bus.hsize), 32'h2);
        check("hprot_hwrite", 32'({bus.hprot, bus.hwrite}), 32'h0);
        check("hwdata", bus.hwdata, 32'h0);
        rst = 1'b0;

        mode = 1;
        run(40);
        check("stream_0", got_i[0], 32'h03020100);
        check("stream_1", got_i[1], 32'h07060504);
        check("stream_2", got_i[2], 32'h0b0a0908);

        stall_left = 3;
        step();
        clear_got();
        jump(32'h2);
        run(20);
        check("jump2_0", got_i[0], 32'h05040302);
        check("jump2_1", got_i[1], 32'h09080706);

        mode = 2;
        stall_left = 2;
        step();
        clear_got();
        jump(32'h2);
        run(20);
        check("rvc_0", 32'(got_i[0][15:0]), 32'h0302);
        check("rvc_1", 32'(got_i[1][15:0]), 32'h0504);
        check("rvc_2", 32'(got_i[2][15:0]), 32'h0706);

        mode = 1;
        err_addr = 32'h40;
        err_waited = 1'b0;
        clear_got();
        jump(32'h3a);
        run(30);
        check("fault_count", got_i.size(), 32'd3);
        check("fault_i0", got_i[0], 32'h3d3c3b3a);
        check("fault_f0", 32'(got_f[0]), 32'h0);
        check("fault_i1", got_i[1], 32'h41403f3e);
        check("fault_f1", 32'(got_f[1]), 32'h1);
        check("fault_i2_lo", 32'(got_i[2][15:0]), 32'h4342);
        check("fault_f2", 32'(got_f[2]), 32'h1);
        check("halt_htrans", 32'(bus.htrans), 32'h0);
        err_addr = 32'hFFFF_FFFF;
        clear_got();
        jump(32'h2);
        run(15);
        check("resume_0", got_i[0], 32'h05040302);

        mode = 0;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        acc_cnt = 0;
        run(20);
        check("full_accepts", acc_cnt, 32'd4);
        check("full_htrans", 32'(bus.htrans), 32'h0);
        clear_got();
        mode = 1;
        run(20);
        check("drain_0", got_i[0], 32'h03020100);

        stall_left = 6;
        run(2);
        stall_left = 0;
        rst = 1'b1;
        step();
        check("rst_vld", 32'(instr_vld_size), 32'h0);
        check("rst_fault", 32'(instr_has_fault), 32'h0);
        check("rst_htrans", 32'(bus.htrans), 32'h0);
        check("rst_haddr", bus.haddr, 32'h0);
        step();
        rst = 1'b0;
        clear_got();
        run(30);
        check("rst_fetch_0", got_i[0], 32'h03020100);
        check("rst_fetch_1", got_i[1], 32'h07060504);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
